// File: rtl/isqrt_rr_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : isqrt_arb_pkg
// Description : Shared types and constants for the isqrt round-robin share
//               arbiter (arbiter FSM states, operand/result widths, tag).
// Config      : ISQRT_ARB_STATS_EN (used by the top, not by this package)
// Revision    : 1.0 - initial release
// ============================================================================
package isqrt_arb_pkg;

   localparam int ISQRT_X_W = 32;
   localparam int ISQRT_Y_W = 16;
   localparam int STAT_W    = 16;

   // Tag id is sized for the largest supported requester count (8).
   localparam int ARB_ID_W  = 3;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      DRAIN   = 2'd1,
      DRAINED = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic                vld;
      logic [ARB_ID_W-1:0] id;
   } arb_tag_t;

endpackage
`default_nettype wire

// File: rtl/isqrt_rr_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : isqrt_rr_share_arbiter_if
// Description : Bundle of requester-side, isqrt-side and status signals of
//               the isqrt share arbiter. slave = arbiter view, master = the
//               surrounding requesters / isqrt / status consumer.
// Config      : ISQRT_ARB_STATS_EN (affects stat_grants content only)
// Revision    : 1.0 - initial release
// ============================================================================
interface isqrt_rr_share_arbiter_if
   import isqrt_arb_pkg::*;
#(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]           req_vld;
   logic [N_REQ*ISQRT_X_W-1:0] req_x;
   logic [N_REQ-1:0]           req_rdy;
   logic [N_REQ-1:0]           rsp_vld;
   logic [ISQRT_Y_W-1:0]       rsp_y;
   logic                       flush;
   logic                       flush_done;
   logic                       err_tag;
   logic                       isqrt_x_vld;
   logic [ISQRT_X_W-1:0]       isqrt_x;
   logic                       isqrt_y_vld;
   logic [ISQRT_Y_W-1:0]       isqrt_y;
   logic [N_REQ*STAT_W-1:0]    stat_grants;

   modport slave (
      input  req_vld, req_x, flush, isqrt_y_vld, isqrt_y,
      output req_rdy, rsp_vld, rsp_y, flush_done, err_tag,
             isqrt_x_vld, isqrt_x, stat_grants
   );

   modport master (
      output req_vld, req_x, flush, isqrt_y_vld, isqrt_y,
      input  req_rdy, rsp_vld, rsp_y, flush_done, err_tag,
             isqrt_x_vld, isqrt_x, stat_grants
   );
endinterface
`default_nettype wire

// File: rtl/isqrt_rr_share_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : isqrt_arb_rr_pick
// Description : Combinational rotate-priority picker. Scans i_req_vld from
//               index i_ptr upward, wrapping modulo N_REQ; first set bit wins.
// Config      : none
// Revision    : 1.0 - initial release
// ============================================================================
module isqrt_arb_rr_pick #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req_vld,
   input  logic [ID_W-1:0]  i_ptr,
   output logic [N_REQ-1:0] o_gnt,
   output logic [ID_W-1:0]  o_id,
   output logic             o_any
);
   // One spare bit so ptr+offset cannot overflow before the wrap.
   logic [ID_W:0]   w_sum;
   logic [ID_W-1:0] w_idx;

   // Rotating scan; the o_any guard freezes the first winner found.
   always_comb begin
      o_gnt = '0;
      o_id  = '0;
      o_any = 1'b0;
      w_sum = '0;
      w_idx = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_sum = {1'b0, i_ptr} + (ID_W+1)'(k);
         if (w_sum >= (ID_W+1)'(N_REQ)) begin
            w_sum = w_sum - (ID_W+1)'(N_REQ);
         end
         w_idx = w_sum[ID_W-1:0];
         if (!o_any && i_req_vld[w_idx]) begin
            o_any        = 1'b1;
            o_gnt[w_idx] = 1'b1;
            o_id         = w_idx;
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/isqrt_rr_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : isqrt_rr_share_arbiter
// Description : Shares one pipelined isqrt among N_REQ requesters. Round-robin
//               issue of one operand per cycle, tag shift register routes each
//               result back to its owner, flush drain FSM, sticky tag error.
// Config      : ISQRT_ARB_STATS_EN - per-requester saturating grant counters
//               on stat_grants; when undefined stat_grants is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module isqrt_rr_share_arbiter
   import isqrt_arb_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int ISQRT_LAT = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   isqrt_rr_share_arbiter_if.slave bus
);
   localparam int ID_W  = $clog2(N_REQ);
   localparam int CNT_W = $clog2(ISQRT_LAT + 1);

   arb_state_e           r_state;
   arb_state_e           w_state_nxt;
   logic [ID_W-1:0]      r_ptr;
   logic [N_REQ-1:0]     w_pick_gnt;
   logic [ID_W-1:0]      w_pick_id;
   logic                 w_pick_any;
   logic                 w_gnt_en;
   logic                 w_flush_done;
   logic [N_REQ-1:0]     w_req_rdy;
   logic                 w_grant;
   logic [ISQRT_X_W-1:0] w_x;
   arb_tag_t             r_tag [ISQRT_LAT];
   arb_tag_t             w_tail;
   logic [N_REQ-1:0]     w_tail_onehot;
   logic [CNT_W-1:0]     r_inflight;
   logic [N_REQ-1:0]     r_rsp_vld;
   logic [ISQRT_Y_W-1:0] r_rsp_y;
   logic                 r_err_tag;

   isqrt_arb_rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .i_req_vld (bus.req_vld),
      .i_ptr     (r_ptr),
      .o_gnt     (w_pick_gnt),
      .o_id      (w_pick_id),
      .o_any     (w_pick_any)
   );

   assign w_req_rdy = w_gnt_en ? w_pick_gnt : '0;
   assign w_grant   = w_gnt_en & w_pick_any;
   assign w_tail    = r_tag[ISQRT_LAT-1];

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= RUN;
      else     r_state <= w_state_nxt;
   end

   // FSM next state: drain waits for every issued operand to retire.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RUN:     if (bus.flush) w_state_nxt = DRAIN;
         DRAIN:   if (r_inflight == '0 && !w_tail.vld) w_state_nxt = DRAINED;
         DRAINED: if (!bus.flush) w_state_nxt = RUN;
         default: w_state_nxt = RUN;
      endcase
   end

   // FSM outputs: a flush request blocks granting in the very same cycle.
   always_comb begin
      w_gnt_en     = (r_state == RUN) && !bus.flush;
      w_flush_done = (r_state == DRAINED);
   end

   // Operand mux from the granted requester slice.
   always_comb begin
      w_x = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_req_rdy[i]) w_x = bus.req_x[i*ISQRT_X_W +: ISQRT_X_W];
      end
   end

   // Round-robin pointer moves just past the winner; holds when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (w_grant) begin
         if (w_pick_id == ID_W'(N_REQ - 1)) r_ptr <= '0;
         else                               r_ptr <= w_pick_id + ID_W'(1);
      end
   end

   // Tag pipe mirrors the isqrt pipeline so the result owner is known.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < ISQRT_LAT; k++) r_tag[k] <= '0;
      end else begin
         r_tag[0].vld <= w_grant;
         r_tag[0].id  <= ARB_ID_W'(w_pick_id);
         for (int k = 1; k < ISQRT_LAT; k++) r_tag[k] <= r_tag[k-1];
      end
   end

   // Count of operands issued but not yet retired from the tag pipe.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_inflight <= '0;
      end else begin
         case ({w_grant, w_tail.vld})
            2'b10:   r_inflight <= r_inflight + CNT_W'(1);
            2'b01:   r_inflight <= r_inflight - CNT_W'(1);
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   // Decode the retiring tag into a one-hot owner vector.
   always_comb begin
      w_tail_onehot = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_tail_onehot[i] = (w_tail.id == ARB_ID_W'(i));
      end
   end

   // Route results to their owner; any valid disagreement is sticky error.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rsp_vld <= '0;
         r_rsp_y   <= '0;
         r_err_tag <= 1'b0;
      end else begin
         if (bus.isqrt_y_vld && w_tail.vld) begin
            r_rsp_vld <= w_tail_onehot;
            r_rsp_y   <= bus.isqrt_y;
         end else begin
            r_rsp_vld <= '0;
         end
         if (bus.isqrt_y_vld != w_tail.vld) r_err_tag <= 1'b1;
      end
   end

`ifdef ISQRT_ARB_STATS_EN
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stats
      logic [STAT_W-1:0] r_cnt;
      // Saturating per-requester grant counter.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_cnt <= '0;
         end else if (w_req_rdy[gi] && r_cnt != {STAT_W{1'b1}}) begin
            r_cnt <= r_cnt + STAT_W'(1);
         end
      end
      assign bus.stat_grants[gi*STAT_W +: STAT_W] = r_cnt;
   end
`else
   assign bus.stat_grants = '0;
`endif

   assign bus.req_rdy     = w_req_rdy;
   assign bus.isqrt_x_vld = w_grant;
   assign bus.isqrt_x     = w_x;
   assign bus.rsp_vld     = r_rsp_vld;
   assign bus.rsp_y       = r_rsp_y;
   assign bus.flush_done  = w_flush_done;
   assign bus.err_tag     = r_err_tag;
endmodule
`default_nettype wire

// File: tb/tb_isqrt_rr_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_isqrt_rr_share_arbiter
// Description : Directed bench for isqrt_rr_share_arbiter with a behavioural
//               isqrt pipeline, arbitration reference model and a result
//               scoreboard checked cycle-exactly at the negative edge.
// Config      : ISQRT_ARB_STATS_EN (grant counter expectations)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_isqrt_rr_share_arbiter;
   localparam int N   = 4;
   localparam int LAT = 16;

   typedef struct {
      int          id;
      logic [15:0] y;
      int          due;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        inj;
   int          checks;
   int          errors;
   int          cyc_n;
   int          m_ptr;
   int          m_cnt [N];
   int          m_last_grant;
   bit          mon_en;
   bit          exp_block;
   bit          exp_fd;
   logic [31:0] opnd [N];
   exp_t        q [$];
   logic        m_pv [LAT];
   logic [15:0] m_py [LAT];

   isqrt_rr_share_arbiter_if #(.N_REQ(N)) bus ();

   isqrt_rr_share_arbiter #(
      .N_REQ     (N),
      .ISQRT_LAT (LAT)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc_n = cyc_n + 1;

   function automatic logic [15:0] isqrt_f(input logic [31:0] x);
      longint r;
      r = 0;
      while ((r + 1) * (r + 1) <= longint'(x)) r++;
      return r[15:0];
   endfunction

   function automatic int pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         int i;
         i = (p + k) % N;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Behavioural isqrt pipeline, reset together with the arbiter.
   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < LAT; k++) begin
            m_pv[k] <= 1'b0;
            m_py[k] <= '0;
         end
      end else begin
         m_pv[0] <= bus.isqrt_x_vld;
         m_py[0] <= isqrt_f(bus.isqrt_x);
         for (int k = 1; k < LAT; k++) begin
            m_pv[k] <= m_pv[k-1];
            m_py[k] <= m_py[k-1];
         end
      end
   end
   assign bus.isqrt_y_vld = m_pv[LAT-1] | inj;
   assign bus.isqrt_y     = m_py[LAT-1];

   // Response scoreboard: each cycle either the due entry appears or nothing.
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (q.size() > 0 && q[0].due == cyc_n) begin
            logic [N-1:0] oh;
            oh = 4'b0001;
            oh = oh << q[0].id;
            chk("rsp_vld", bus.rsp_vld, oh);
            chk("rsp_y", bus.rsp_y, q[0].y);
            void'(q.pop_front());
         end else begin
            chk("rsp_vld_idle", bus.rsp_vld, 0);
            if (q.size() > 0 && q[0].due < cyc_n) begin
               chk("rsp_missed", 1, 0);
               void'(q.pop_front());
            end
         end
      end
   end

   // One clock cycle with inputs already driven; checks grant against model.
   task automatic cycle();
      int           g;
      logic [N-1:0] er;
      #2;
      g  = (exp_block || bus.flush) ? -1 : pick(bus.req_vld, m_ptr);
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("req_rdy", bus.req_rdy, er);
      chk("isqrt_x_vld", bus.isqrt_x_vld, (g >= 0));
      chk("flush_done", bus.flush_done, exp_fd);
      if (g >= 0) begin
         chk("isqrt_x", bus.isqrt_x, opnd[g]);
         q.push_back('{g, isqrt_f(opnd[g]), cyc_n + LAT + 1});
         m_ptr        = (g + 1) % N;
         m_cnt[g]     = m_cnt[g] + 1;
         m_last_grant = cyc_n;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input logic [31:0] a, b, c, d);
      opnd[0] = a; opnd[1] = b; opnd[2] = c; opnd[3] = d;
      for (int i = 0; i < N; i++) bus.req_x[i*32 +: 32] = opnd[i];
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rsp_vld"}, bus.rsp_vld, 0);
      chk({tag, "_rsp_y"}, bus.rsp_y, 0);
      chk({tag, "_err_tag"}, bus.err_tag, 0);
      chk({tag, "_flush_done"}, bus.flush_done, 0);
      chk({tag, "_stat"}, bus.stat_grants, 0);
      chk({tag, "_req_rdy"}, bus.req_rdy, 0);
   endtask

   task automatic check_stats(input string tag);
      for (int i = 0; i < N; i++) begin
`ifdef ISQRT_ARB_STATS_EN
         chk(tag, bus.stat_grants[i*16 +: 16], m_cnt[i][15:0]);
`else
         chk(tag, bus.stat_grants[i*16 +: 16], 0);
`endif
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; errors = 0; cyc_n = 0; m_ptr = 0; m_last_grant = 0;
      mon_en = 0; exp_block = 0; exp_fd = 0; inj = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      rst = 1'b1; bus.req_vld = '0; bus.flush = 1'b0;
      set_ops(0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      mon_en = 1;

      // Fairness: all four requesting, grants 0,1,2,3,0,1,2,3.
      set_ops(1, 4, 9, 16);
      bus.req_vld = 4'b1111;
      repeat (8) cycle();
      bus.req_vld = '0;
      repeat (LAT + 3) cycle();
      chk("fair_drained", q.size(), 0);

      // Single request of 144 to requester 0.
      set_ops(144, 0, 0, 0);
      bus.req_vld = 4'b0001;
      cycle();
      bus.req_vld = '0;
      repeat (LAT + 3) cycle();
      chk("single_drained", q.size(), 0);
      chk("single_err_tag", bus.err_tag, 0);

      // Sparse: requester 1 alone moves ptr to 2, then 1 and 3 -> 3 first.
      set_ops(0, 25, 0, 49);
      bus.req_vld = 4'b0010;
      cycle();
      chk("sparse_ptr", m_ptr, 2);
      bus.req_vld = 4'b1010;
      repeat (2) cycle();
      bus.req_vld = '0;
      repeat (LAT + 3) cycle();
      chk("sparse_drained", q.size(), 0);

      // Flush with 5 grants in flight.
      set_ops(100, 121, 169, 196);
      bus.req_vld = 4'b1111;
      repeat (5) cycle();
      bus.flush = 1'b1;
      for (int t = 0; t < 64; t++) begin
         if (cyc_n >= m_last_grant + LAT + 2) break;
         cycle();
      end
      chk("flush_all_out", q.size(), 0);
      exp_fd = 1;
      repeat (2) cycle();
      bus.flush = 1'b0;
      exp_block = 1;
      cycle();
      exp_block = 0;
      exp_fd = 0;
      repeat (2) cycle();
      bus.req_vld = '0;
      repeat (LAT + 3) cycle();
      chk("resume_drained", q.size(), 0);
      check_stats("stat_grants");

      // Stray isqrt result with an empty tag pipe.
      inj = 1'b1;
      cycle();
      inj = 1'b0;
      cycle();
      chk("err_tag_set", bus.err_tag, 1);
      repeat (3) cycle();
      chk("err_tag_sticky", bus.err_tag, 1);

      // Reset clears the sticky error.
      rst = 1'b1;
      q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_ptr = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      chk("err_tag_cleared", bus.err_tag, 0);

      // Reset mid-stream with 8 operations in flight.
      set_ops(36, 64, 81, 225);
      bus.req_vld = 4'b1111;
      repeat (8) cycle();
      rst = 1'b1;
      bus.req_vld = '0;
      q.delete();
      @(posedge clk);
      #1;
      check_reset_outputs("midrst");
      rst = 1'b0;
      m_ptr = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      repeat (LAT + 4) cycle();
      chk("midrst_err_tag", bus.err_tag, 0);
      chk("midrst_empty", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
